seven_segment_scanner: RTL and testbench
========================================

# seven_segment_scanner

Time-multiplexed driver for a bank of common-anode seven-segment digits, generalising the single-digit decoder to `DIGITS` digits sharing one segment bus. A loadable shadow register holds the value, and a prescaled scan FSM drives one digit at a time with an anti-ghosting gap between digits. Decimal or hex glyph mode is selectable. It sits at the processor output stage, fed from a register or memory-mapped port.

## Interface
- `DIGITS`, 4: number of digits; legal 1..16.
- `PRESCALE`, 50000: clock cycles each digit is driven; legal ≥1.
- `GAP_CYCLES`, 16: cycles with all digits off between digits; legal ≥1.
- `clock  in  1`: single clock, rising edge.
- `resetn  in  1`: asynchronous, active-low reset.
- `value  in  4*DIGITS`: nibble i (`value[4i+3:4i]`) is digit i; digit 0 is the rightmost, least significant digit.
- `load  in  1`: when 1 on a rising edge, `value` is captured into the shadow register.
- `hex_mode  in  1`: 1 = glyphs 0-F; 0 = glyphs 0-9, with codes 10-15 blank.
- `blank  in  1`: 1 = all digits dark; scanning continues.
- `seg  out  7`: `{A,B,C,D,E,F,G}`, active-low; bit 6 = A.
- `an  out  DIGITS`: digit enables, active-low; at most one bit is 0.
- `frame_done  out  1`: one-cycle pulse at the end of digit `DIGITS-1` drive.

## Operation
- Registers:
  - shadow register, `4*DIGITS` bits;
  - `hex_q` and `blank_q`, sampled every cycle;
  - `state` ∈ {GAP, DRIVE};
  - `cnt`, wide enough for max(`PRESCALE`, `GAP_CYCLES`)-1;
  - `idx`, digit index of width max(1, clog2(`DIGITS`)).
- Reset values:
  - shadow = 0, `hex_q` = 0, `blank_q` = 0;
  - `state` = GAP, `cnt` = 0, `idx` = `DIGITS`-1.
  - Resulting outputs: `seg` = 7'b1111111, `an` = all 1, `frame_done` = 0.
- GAP state: `cnt` increments each cycle. On the edge where `cnt` = `GAP_CYCLES`-1, the FSM goes to DRIVE, `cnt` resets to 0, and `idx` becomes `idx`+1, wrapping from `DIGITS`-1 to 0.
- DRIVE state: `cnt` increments each cycle. On the edge where `cnt` = `PRESCALE`-1, the FSM goes to GAP and `cnt` resets to 0. If `idx` = `DIGITS`-1 on that edge, `frame_done` = 1 for the next cycle.
- Outputs decode from registers only; there is no combinational path from inputs to outputs.
  - `an[idx]` = 0 only when `state` = DRIVE.
  - `seg` = ~glyph(shadow nibble `idx`) in DRIVE with `blank_q` = 0; otherwise 7'b1111111.
- Glyphs, in active-high `{A..G}` order:

| Code | Glyph | Code | Glyph |
|---|---|---|---|
| 0 | 1111110 | 8 | 1111111 |
| 1 | 0110000 | 9 | 1111011 |
| 2 | 1101101 | A | 1110111 |
| 3 | 1111001 | b | 0011111 |
| 4 | 0110011 | C | 1001110 |
| 5 | 1011011 | d | 0111101 |
| 6 | 1011111 | E | 1001111 |
| 7 | 1110000 | F | 1000111 |

  Codes A-F are shown only when `hex_q` = 1; in decimal mode they produce 0000000.
- `load` may be asserted on any cycle, including a digit-switch edge. A capture on edge k is visible on `seg` from cycle k+1, mid-digit included. There is no tearing protection.
- `DIGITS` = 1: `idx` stays 0, and `frame_done` pulses at every DRIVE end.
- Reset asserted mid-scan: all registers immediately take their reset values, and outputs go dark asynchronously.

## Timing
- `load` → `seg`: 1 cycle. `hex_mode` / `blank` → `seg`: 1 cycle.
- First digit after reset release: `an[0]` falls after `GAP_CYCLES` edges.
- Scan period: `DIGITS`·(`PRESCALE`+`GAP_CYCLES`) cycles; each `an` low pulse lasts exactly `PRESCALE` cycles.
- `frame_done` is high during the first GAP cycle after digit `DIGITS`-1.

## Configuration
- `SEVSEG_LEADING_ZERO_BLANK_EN` defined:
  - Digit i > 0 is forced dark (`seg` = 7'b1111111) when shadow nibbles i..`DIGITS`-1 are all 0.
  - Its `an` still pulses, so timing is unchanged. Digit 0 is never suppressed.
- Not defined: every digit shows its glyph, zeros included.

## Test plan
- Reset, with `DIGITS`=4, `PRESCALE`=4, `GAP_CYCLES`=2: during reset `seg`=7'h7F and `an`=4'hF. After release, `an`=4'hE from cycle 2 to cycle 5, then `an`=4'hF for 2 cycles, then `an`=4'hD.
- `load` with `value`=16'h1234, `hex_mode`=0: digit 0 shows `seg`=~7'b0110011 ('4'), digit 3 shows ~7'b0110000 ('1'). `frame_done` pulses once per 24 cycles.
- `value`=16'hAB0F: with `hex_mode`=1, digit 3 shows ~7'b1110111 and digit 0 shows ~7'b1000111. With `hex_mode`=0, those digits show 7'h7F while digit 1 shows '0'.
- `blank`=1 mid-drive: `seg`=7'h7F one cycle later while the `an` sequence continues unchanged. Deasserting `blank` restores the glyph one cycle later.
- `load` of 16'h0009 on the edge where digit 0 enters DRIVE: the new glyph appears at the next cycle. With `SEVSEG_LEADING_ZERO_BLANK_EN`, digits 1-3 stay 7'h7F; without it they show '0'.
- `resetn` pulled low mid-DRIVE of digit 2: `an`=4'hF and `seg`=7'h7F immediately, and the shadow register clears to 0.

Source files
------------

// File: rtl/seven_segment_scanner_if.sv
// rtl/seven_segment_scanner_if.sv - value/control and display bus of the seven-segment scanner
interface seven_segment_scanner_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic                hex_mode;
  logic                blank;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  modport master (
    output value, load, hex_mode, blank,
    input  seg, an, frame_done
  );

  modport slave (
    input  value, load, hex_mode, blank,
    output seg, an, frame_done
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - multiplexed common-anode seven-segment scan driver
// Optional build macro SEVSEG_LEADING_ZERO_BLANK_EN darkens leading zero digits.
module seven_segment_scanner #(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 50000,
  parameter int GAP_CYCLES = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  seven_segment_scanner_if.slave bus
);
  localparam int CMAX = (PRESCALE > GAP_CYCLES) ? PRESCALE : GAP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  typedef enum logic {GAP = 1'b0, DRIVE = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic                frame_q, frame_nxt;
  logic [4*DIGITS-1:0] shadow;
  logic                hex_q, blank_q;
  logic [3:0]          nib;
  logic                suppress;
  logic [6:0]          seg_d;
  logic [DIGITS-1:0]   an_d;

  function automatic logic [6:0] glyph(input logic [3:0] code, input logic hex);
    case (code)
      4'h0:    glyph = 7'b1111110;
      4'h1:    glyph = 7'b0110000;
      4'h2:    glyph = 7'b1101101;
      4'h3:    glyph = 7'b1111001;
      4'h4:    glyph = 7'b0110011;
      4'h5:    glyph = 7'b1011011;
      4'h6:    glyph = 7'b1011111;
      4'h7:    glyph = 7'b1110000;
      4'h8:    glyph = 7'b1111111;
      4'h9:    glyph = 7'b1111011;
      4'hA:    glyph = hex ? 7'b1110111 : 7'b0000000;
      4'hB:    glyph = hex ? 7'b0011111 : 7'b0000000;
      4'hC:    glyph = hex ? 7'b1001110 : 7'b0000000;
      4'hD:    glyph = hex ? 7'b0111101 : 7'b0000000;
      4'hE:    glyph = hex ? 7'b1001111 : 7'b0000000;
      default: glyph = hex ? 7'b1000111 : 7'b0000000;
    endcase
  endfunction

  // Reset parks idx on the last digit so the first GAP wraps it onto digit 0.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= GAP;
      cnt     <= '0;
      idx     <= IDX_LAST;
      frame_q <= 1'b0;
      shadow  <= '0;
      hex_q   <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      frame_q <= frame_nxt;
      hex_q   <= bus.hex_mode;
      blank_q <= bus.blank;
      if (bus.load) shadow <= bus.value;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    frame_nxt = 1'b0;
    case (state)
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = DRIVE;
          cnt_nxt   = '0;
          idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
      end
      default: begin
        if (cnt == PRE_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
          frame_nxt = (idx == IDX_LAST);
        end
      end
    endcase
  end

  assign nib = shadow[4*idx +: 4];

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz;
  logic              zero_above;

  // lz[i] is set when nibble i and every nibble above it are zero; digit 0 never qualifies.
  always_comb begin
    lz         = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (shadow[4*i +: 4] == 4'h0);
      lz[i]      = zero_above;
    end
  end

  assign suppress = lz[idx];
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    an_d  = '1;
    seg_d = 7'b1111111;
    if (state == DRIVE) begin
      an_d[idx] = 1'b0;
      if (!blank_q && !suppress) seg_d = ~glyph(nib, hex_q);
    end
  end

  assign bus.seg        = seg_d;
  assign bus.an         = an_d;
  assign bus.frame_done = frame_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - directed self-checking bench for seven_segment_scanner
module tb_seven_segment_scanner;
  logic clock = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h01;
`endif

  seven_segment_scanner_if #(.DIGITS(4)) bus ();

  seven_segment_scanner #(.DIGITS(4), .PRESCALE(4), .GAP_CYCLES(2)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic go(input int target);
    while (cyc < target) tick();
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  initial begin
    resetn       = 1'b0;
    bus.value    = '0;
    bus.load     = 1'b0;
    bus.hex_mode = 1'b0;
    bus.blank    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_seg", bus.seg, 7'h7F);
    check("rst_an", bus.an, 4'hF);
    check("rst_frame", bus.frame_done, 1'b0);

    resetn = 1'b1;
    cyc    = 0;
    go(1);  check("c1_an", bus.an, 4'hF);
    go(2);  check("c2_an", bus.an, 4'hE);
    check("c2_seg_zero", bus.seg, 7'h01);
    go(5);  check("c5_an", bus.an, 4'hE);
    go(6);  check("c6_gap_an", bus.an, 4'hF);
    go(7);  check("c7_gap_an", bus.an, 4'hF);
    go(8);  check("c8_an", bus.an, 4'hD);

    bus.value = 16'h1234;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
    check("load_d1_seg", bus.seg, 7'h06);
    check("load_d1_an", bus.an, 4'hD);
    go(20); check("d3_an", bus.an, 4'h7);
    check("d3_seg_1", bus.seg, 7'h4F);
    go(23); check("fd_pre", bus.frame_done, 1'b0);
    go(24); check("fd_pulse", bus.frame_done, 1'b1);
    check("fd_gap_an", bus.an, 4'hF);
    go(25); check("fd_one_cycle", bus.frame_done, 1'b0);
    go(26); check("d0_an", bus.an, 4'hE);
    check("d0_seg_4", bus.seg, 7'h4C);
    go(47); check("fd2_pre", bus.frame_done, 1'b0);
    go(48); check("fd2_pulse", bus.frame_done, 1'b1);

    bus.value    = 16'hAB0F;
    bus.load     = 1'b1;
    bus.hex_mode = 1'b1;
    tick();
    bus.load     = 1'b0;
    go(50); check("hex_d0_an", bus.an, 4'hE);
    check("hex_d0_F", bus.seg, 7'h38);
    go(68); check("hex_d3_an", bus.an, 4'h7);
    check("hex_d3_A", bus.seg, 7'h08);
    bus.hex_mode = 1'b0;
    tick();
    check("dec_d3_blank", bus.seg, 7'h7F);
    check("dec_d3_an", bus.an, 4'h7);
    go(74); check("dec_d0_an", bus.an, 4'hE);
    check("dec_d0_blank", bus.seg, 7'h7F);
    go(80); check("dec_d1_an", bus.an, 4'hD);
    check("dec_d1_zero", bus.seg, 7'h01);

    bus.blank = 1'b1;
    tick();
    check("blank_seg", bus.seg, 7'h7F);
    check("blank_an", bus.an, 4'hD);
    bus.blank = 1'b0;
    tick();
    check("unblank_seg", bus.seg, 7'h01);

    go(97);
    bus.value = 16'h0009;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
    check("sw_load_an", bus.an, 4'hE);
    check("sw_load_seg9", bus.seg, 7'h04);
    go(104); check("lz_d1_an", bus.an, 4'hD);
    check("lz_d1_seg", bus.seg, LZ);
    go(110); check("lz_d2_seg", bus.seg, LZ);
    go(116); check("lz_d3_an", bus.an, 4'h7);
    check("lz_d3_seg", bus.seg, LZ);

    go(135); check("pre_rst_an", bus.an, 4'hB);
    check("pre_rst_seg", bus.seg, LZ);
    resetn = 1'b0;
    #1;
    check("async_rst_an", bus.an, 4'hF);
    check("async_rst_seg", bus.seg, 7'h7F);
    tick();
    check("rst_hold_frame", bus.frame_done, 1'b0);
    resetn = 1'b1;
    cyc    = 0;
    go(2);  check("post_rst_an", bus.an, 4'hE);
    check("post_rst_shadow0", bus.seg, 7'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
